mcu_port_responder: RTL and testbench



---
 rtl/mcu_port_responder.sv | 152 +++++++++++++++
 tb/tb_mcu_port_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_port_responder.sv
// Memory-side responder for the cache MCU port: grants the port, forwards
// single-word writes and two-word reads to the backend command channel,
// buffers read words and returns them on a fixed schedule after the ack.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | grant follows registered !dma_busy; accept cache request
// S_WR_ISSUE   | write command presented to backend, wait for ready
// S_RD_ISSUE   | read command presented to backend, wait for ready
// S_RD_COLLECT | capture returned read words into the 2-entry buffer
// S_ACK        | single-cycle mem_ack pulse
// S_RD_DELIVER | count RD_LAT from the ack, drive buffer words to the cache
// S_HOLDOFF    | wait for the cache to drop mem_do_act before re-arming
module mcu_port_responder #(
  parameter int RD_LAT = 4  // legal 2..8; cycles from ack to first read word
) (
  input  logic        MCU_CLK,
  input  logic        RST,
  input  logic        dma_busy,
  output logic        dma_mcu_access,
  input  logic        mem_do_act,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_dataintomem,
  output logic        mem_ack,
  output logic [31:0] mem_datafrommem,
  output logic        bk_cmd_valid,
  input  logic        bk_cmd_ready,
  output logic        bk_cmd_we,
  output logic [29:0] bk_cmd_addr,
  output logic [31:0] bk_cmd_wdata,
  input  logic        bk_rvalid,
  input  logic [31:0] bk_rdata,
  output logic        proto_err
);

  localparam int         BURST_LEN = 2;
  localparam logic [1:0] LP_LAST   = 2'(BURST_LEN - 1);
  localparam logic [1:0] LP_BURST  = 2'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ISSUE, S_RD_ISSUE, S_RD_COLLECT, S_ACK, S_RD_DELIVER, S_HOLDOFF
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;
  logic [29:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_buf0;
  logic [31:0] r_buf1;
  logic [1:0]  r_wcnt;
  logic [3:0]  r_cnt;
  logic        r_proto_err;
  logic        w_accept;
  logic        w_capture;
  logic        w_stray;
  logic [1:0]  w_unused_addr_hi;

  assign w_unused_addr_hi = mem_addr[31:30];

  assign w_accept = (r_state == S_IDLE) & mem_do_act & r_grant;

  // A word arriving together with the read command's ready is word 0.
  assign w_capture = bk_rvalid & (r_wcnt < LP_BURST) &
                     (((r_state == S_RD_ISSUE) & bk_cmd_ready) | (r_state == S_RD_COLLECT));
  assign w_stray   = bk_rvalid & ~w_capture;

  // State, request latch, read buffer, delivery down-counter and sticky error.
  always_ff @(posedge MCU_CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_grant     <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_wcnt      <= '0;
      r_cnt       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= ~dma_busy;
      if (w_accept) begin
        r_addr  <= mem_addr[29:0];
        r_we    <= mem_we;
        r_wdata <= mem_dataintomem;
        r_wcnt  <= '0;
      end
      if (w_capture) begin
        if (r_wcnt[0]) r_buf1 <= bk_rdata;
        else           r_buf0 <= bk_rdata;
        r_wcnt <= r_wcnt + 2'd1;
      end
      if (w_stray) r_proto_err <= 1'b1;
      // Loaded at the ack; word 0 goes out when it reaches 1, word 1 at 0.
      if (r_state == S_ACK)
        r_cnt <= 4'(RD_LAT);
      else if ((r_state == S_RD_DELIVER) && (r_cnt != 4'd0))
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt     = r_state;
    dma_mcu_access  = 1'b0;
    mem_ack         = 1'b0;
    mem_datafrommem = '0;
    bk_cmd_valid    = 1'b0;
    bk_cmd_we       = 1'b0;
    bk_cmd_addr     = r_addr;
    bk_cmd_wdata    = r_wdata;
    proto_err       = r_proto_err;
    case (r_state)
      S_IDLE: begin
        dma_mcu_access = r_grant;
        if (w_accept) w_state_nxt = mem_we ? S_WR_ISSUE : S_RD_ISSUE;
      end
      S_WR_ISSUE: begin
        bk_cmd_valid = 1'b1;
        bk_cmd_we    = 1'b1;
        if (bk_cmd_ready) w_state_nxt = S_ACK;
      end
      S_RD_ISSUE: begin
        bk_cmd_valid = 1'b1;
        if (bk_cmd_ready) w_state_nxt = S_RD_COLLECT;
      end
      S_RD_COLLECT: begin
        if (w_capture && (r_wcnt == LP_LAST)) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        mem_ack     = 1'b1;
        w_state_nxt = r_we ? S_HOLDOFF : S_RD_DELIVER;
      end
      S_RD_DELIVER: begin
        if (r_cnt == 4'd1) mem_datafrommem = r_buf0;
        if (r_cnt == 4'd0) begin
          mem_datafrommem = r_buf1;
          w_state_nxt     = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (!mem_do_act) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcu_port_responder.sv
// Directed bench for mcu_port_responder: read (fast/slow backend), write,
// DMA arbitration, stray read data and reset during a read.
module tb_mcu_port_responder;

  logic        MCU_CLK = 1'b0;
  logic        RST;
  logic        dma_busy;
  logic        dma_mcu_access;
  logic        mem_do_act;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_dataintomem;
  logic        mem_ack;
  logic [31:0] mem_datafrommem;
  logic        bk_cmd_valid;
  logic        bk_cmd_ready;
  logic        bk_cmd_we;
  logic [29:0] bk_cmd_addr;
  logic [31:0] bk_cmd_wdata;
  logic        bk_rvalid;
  logic [31:0] bk_rdata;
  logic        proto_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_ack    = 0;
  int n_cmd    = 0;
  int n_wcmd   = 0;

  always #5 MCU_CLK = ~MCU_CLK;

  mcu_port_responder #(.RD_LAT(4)) dut (
    .MCU_CLK        (MCU_CLK),
    .RST            (RST),
    .dma_busy       (dma_busy),
    .dma_mcu_access (dma_mcu_access),
    .mem_do_act     (mem_do_act),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_dataintomem(mem_dataintomem),
    .mem_ack        (mem_ack),
    .mem_datafrommem(mem_datafrommem),
    .bk_cmd_valid   (bk_cmd_valid),
    .bk_cmd_ready   (bk_cmd_ready),
    .bk_cmd_we      (bk_cmd_we),
    .bk_cmd_addr    (bk_cmd_addr),
    .bk_cmd_wdata   (bk_cmd_wdata),
    .bk_rvalid      (bk_rvalid),
    .bk_rdata       (bk_rdata),
    .proto_err      (proto_err)
  );

  // Event counters sampled mid-cycle: ack pulses and backend handshakes.
  always @(negedge MCU_CLK) begin
    if (!RST) begin
      if (mem_ack) n_ack++;
      if (bk_cmd_valid && bk_cmd_ready) begin
        n_cmd++;
        if (bk_cmd_we) n_wcmd++;
      end
    end
  end

  task automatic cyc();
    @(posedge MCU_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " grant"},  32'(dma_mcu_access), 32'd0);
    chk({tag, " ack"},    32'(mem_ack),        32'd0);
    chk({tag, " rdata"},  mem_datafrommem,     32'd0);
    chk({tag, " valid"},  32'(bk_cmd_valid),   32'd0);
    chk({tag, " we"},     32'(bk_cmd_we),      32'd0);
    chk({tag, " addr"},   32'(bk_cmd_addr),    32'd0);
    chk({tag, " wdata"},  bk_cmd_wdata,        32'd0);
    chk({tag, " perr"},   32'(proto_err),      32'd0);
  endtask

  // Called in the ack cycle K of a read; checks K..K+6 and ends in K+7 (IDLE).
  task automatic deliver(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                         input int exp_acks);
    logic [31:0] exp_d;
    chk({tag, " ack pulse"}, 32'(mem_ack), 32'd1);
    chk({tag, " data@ack"}, mem_datafrommem, 32'd0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      mem_do_act = (j <= 2);
      exp_d = (j == 4) ? w0 : ((j == 5) ? w1 : 32'd0);
      chk($sformatf("%s ack@+%0d", tag, j), 32'(mem_ack), 32'd0);
      chk($sformatf("%s data@+%0d", tag, j), mem_datafrommem, exp_d);
      chk($sformatf("%s grant@+%0d", tag, j), 32'(dma_mcu_access), 32'd0);
    end
    cyc();
    chk({tag, " ack count"}, 32'(n_ack), 32'(exp_acks));
  endtask

  initial begin
    RST = 1'b1; dma_busy = 1'b1; mem_do_act = 1'b0; mem_addr = '0; mem_we = 1'b0;
    mem_dataintomem = '0; bk_cmd_ready = 1'b0; bk_rvalid = 1'b0; bk_rdata = '0;
    cyc(); cyc();
    chk_reset("reset");
    RST = 1'b0;

    // DMA owns the backend: no grant, request ignored.
    cyc();
    chk("busy grant", 32'(dma_mcu_access), 32'd0);
    mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0104;
    cyc();
    chk("busy ignore valid", 32'(bk_cmd_valid), 32'd0);
    cyc();
    chk("busy ignore valid2", 32'(bk_cmd_valid), 32'd0);
    mem_do_act = 1'b0; dma_busy = 1'b0;
    cyc();
    chk("grant after release", 32'(dma_mcu_access), 32'd1);

    // Read, fast backend.
    mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0104;
    cyc();
    chk("rdf valid", 32'(bk_cmd_valid), 32'd1);
    chk("rdf we", 32'(bk_cmd_we), 32'd0);
    chk("rdf addr", 32'(bk_cmd_addr), 32'h104);
    chk("rdf grant off", 32'(dma_mcu_access), 32'd0);
    bk_cmd_ready = 1'b1;
    cyc();
    bk_cmd_ready = 1'b0; bk_rvalid = 1'b1; bk_rdata = 32'hAAAA_0001;
    chk("rdf valid dropped", 32'(bk_cmd_valid), 32'd0);
    cyc();
    bk_rdata = 32'hBBBB_0002;
    chk("rdf no early ack", 32'(mem_ack), 32'd0);
    cyc();
    bk_rvalid = 1'b0;
    deliver("rdf", 32'hAAAA_0001, 32'hBBBB_0002, 1);
    chk("rdf back to idle", 32'(dma_mcu_access), 32'd1);
    chk("rdf perr", 32'(proto_err), 32'd0);

    // Read, slow backend; DMA rises mid-read and must not abort it.
    mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 32'hC000_0207;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rds stall valid %0d", i), 32'(bk_cmd_valid), 32'd1);
      chk($sformatf("rds stall addr %0d", i), 32'(bk_cmd_addr), 32'h207);
      cyc();
    end
    bk_cmd_ready = 1'b1;
    chk("rds valid at ready", 32'(bk_cmd_valid), 32'd1);
    cyc();
    bk_cmd_ready = 1'b0; dma_busy = 1'b1;
    for (int i = 0; i < 9; i++) cyc();
    bk_rvalid = 1'b1; bk_rdata = 32'h1111_2222;
    cyc();
    bk_rvalid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("rds wait ack %0d", i), 32'(mem_ack), 32'd0);
      cyc();
    end
    bk_rvalid = 1'b1; bk_rdata = 32'h3333_4444;
    chk("rds no ack before w1", 32'(mem_ack), 32'd0);
    cyc();
    bk_rvalid = 1'b0;
    deliver("rds", 32'h1111_2222, 32'h3333_4444, 2);
    chk("rds busy grant", 32'(dma_mcu_access), 32'd0);
    mem_do_act = 1'b1;
    cyc(); cyc();
    chk("rds busy ignore", 32'(bk_cmd_valid), 32'd0);
    mem_do_act = 1'b0; dma_busy = 1'b0;
    cyc();
    chk("rds regrant", 32'(dma_mcu_access), 32'd1);

    // Write with mem_do_act held 3 cycles past the ack.
    mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0020; mem_dataintomem = 32'hDEAD_BEEF;
    cyc();
    chk("wr valid", 32'(bk_cmd_valid), 32'd1);
    chk("wr we", 32'(bk_cmd_we), 32'd1);
    chk("wr addr", 32'(bk_cmd_addr), 32'h20);
    chk("wr wdata", bk_cmd_wdata, 32'hDEAD_BEEF);
    bk_cmd_ready = 1'b1;
    cyc();
    bk_cmd_ready = 1'b0;
    chk("wr ack", 32'(mem_ack), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      if (j == 4) mem_do_act = 1'b0;
      chk($sformatf("wr hold ack %0d", j), 32'(mem_ack), 32'd0);
      chk($sformatf("wr hold valid %0d", j), 32'(bk_cmd_valid), 32'd0);
      chk($sformatf("wr hold grant %0d", j), 32'(dma_mcu_access), 32'd0);
    end
    cyc();
    chk("wr idle grant", 32'(dma_mcu_access), 32'd1);
    cyc();
    chk("wr no reaccept", 32'(bk_cmd_valid), 32'd0);
    chk("wr ack count", 32'(n_ack), 32'd3);
    chk("cmd count", 32'(n_cmd), 32'd3);
    chk("write cmd count", 32'(n_wcmd), 32'd1);

    // Stray read data in IDLE.
    bk_rvalid = 1'b1; bk_rdata = 32'h0BAD_0BAD;
    cyc();
    bk_rvalid = 1'b0;
    chk("perr set", 32'(proto_err), 32'd1);
    chk("perr grant", 32'(dma_mcu_access), 32'd1);
    chk("perr data", mem_datafrommem, 32'd0);
    chk("perr valid", 32'(bk_cmd_valid), 32'd0);
    cyc(); cyc();
    chk("perr sticky", 32'(proto_err), 32'd1);

    // Reset in RD_COLLECT after one word, then a fresh read.
    mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0300;
    cyc();
    bk_cmd_ready = 1'b1;
    cyc();
    bk_cmd_ready = 1'b0; bk_rvalid = 1'b1; bk_rdata = 32'h5555_5555;
    cyc();
    bk_rvalid = 1'b0; RST = 1'b1; mem_do_act = 1'b0;
    cyc();
    chk_reset("midreset");
    RST = 1'b0;
    cyc();
    chk("post reset grant", 32'(dma_mcu_access), 32'd1);
    mem_do_act = 1'b1; mem_addr = 32'h0000_0301;
    cyc();
    chk("rr addr", 32'(bk_cmd_addr), 32'h301);
    bk_cmd_ready = 1'b1; bk_rvalid = 1'b1; bk_rdata = 32'h6666_0001;
    cyc();
    bk_cmd_ready = 1'b0; bk_rdata = 32'h6666_0002;
    cyc();
    bk_rvalid = 1'b0;
    deliver("rr", 32'h6666_0001, 32'h6666_0002, 4);
    chk("rr perr clear", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
